// File: rtl/control_booth.sv
// Sequencing FSM for the 3-bit radix-2 Booth multiplier datapath.
// Define BOOTH_SKIP_EN to bypass OPERA when the Booth pair is 00 or 11.
module control_booth #(
  parameter int unsigned N_ITER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [1:0] q,
  output logic       start,
  output logic       cargaA,
  output logic       cargaQ,
  output logic       cargaM,
  output logic       suma,
  output logic       desplazaAQ,
  output logic       ocupado,
  output logic       fin
);

  localparam int unsigned CntW = $clog2(N_ITER + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(N_ITER - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCarga,
    StEval,
    StOpera,
    StDesplaza,
    StFin
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      qreg_q, qreg_d;
  logic            skip;

`ifdef BOOTH_SKIP_EN
  assign skip = (q == 2'b00) || (q == 2'b11);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qreg_d  = qreg_q;
    case (state_q)
      StIdle: begin
        if (inicio) state_d = StCarga;
      end
      StCarga: begin
        cnt_d   = '0;
        state_d = StEval;
      end
      StEval: begin
        qreg_d  = q;
        state_d = skip ? StDesplaza : StOpera;
      end
      StOpera: begin
        state_d = StDesplaza;
      end
      StDesplaza: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LastIter) ? StFin : StEval;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q (Moore timing).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      qreg_q     <= 2'b00;
      start      <= 1'b0;
      cargaA     <= 1'b0;
      cargaQ     <= 1'b0;
      cargaM     <= 1'b0;
      suma       <= 1'b0;
      desplazaAQ <= 1'b0;
      ocupado    <= 1'b0;
      fin        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qreg_q     <= qreg_d;
      start      <= (state_d == StCarga);
      cargaQ     <= (state_d == StCarga);
      cargaM     <= (state_d == StCarga);
      cargaA     <= (state_d == StOpera) && (qreg_d == 2'b01 || qreg_d == 2'b10);
      suma       <= (state_d == StOpera) && (qreg_d == 2'b01);
      desplazaAQ <= (state_d == StDesplaza);
      ocupado    <= (state_d != StIdle);
      fin        <= (state_d == StFin);
    end
  end

endmodule

// File: tb/tb_control_booth.sv
// Directed bench for control_booth with a small behavioural Booth datapath.
module tb_control_booth;

  logic       clk = 1'b0;
  logic       reset, inicio;
  logic [1:0] q;
  logic       start, cargaA, cargaQ, cargaM, suma, desplazaAQ, ocupado, fin;
  logic [7:0] outs;

  int checks = 0;
  int failures = 0;

  // Datapath model: A accumulator, Q = {multiplier, Q-1}, M multiplicand
  logic [2:0] mcador = 3'b000;
  logic [2:0] mcando = 3'b000;
  logic [2:0] ma = 3'b000;
  logic [3:0] mq = 4'b0000;
  logic [2:0] mm = 3'b000;

`ifdef BOOTH_SKIP_EN
  localparam int Fin32 = 10;
  localparam int FinM4 = 9;
  localparam int Fin0  = 8;
  localparam logic [31:0] Sh32 = 32'h250;
  localparam logic [31:0] ShM4 = 32'h128;
  localparam logic [31:0] Sh0  = 32'h0A8;
`else
  localparam int Fin32 = 11;
  localparam int FinM4 = 11;
  localparam int Fin0  = 11;
  localparam logic [31:0] Sh32 = 32'h490;
  localparam logic [31:0] ShM4 = 32'h490;
  localparam logic [31:0] Sh0  = 32'h490;
`endif

  always #5 clk = ~clk;

  control_booth #(.N_ITER(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .inicio     (inicio),
    .q          (q),
    .start      (start),
    .cargaA     (cargaA),
    .cargaQ     (cargaQ),
    .cargaM     (cargaM),
    .suma       (suma),
    .desplazaAQ (desplazaAQ),
    .ocupado    (ocupado),
    .fin        (fin)
  );

  assign outs = {start, cargaA, cargaQ, cargaM, suma, desplazaAQ, ocupado, fin};
  assign q = mq[1:0];

  always @(posedge clk) begin
    if (start) ma <= 3'b000;
    if (cargaQ) mq <= {mcador, 1'b0};
    if (cargaM) mm <= mcando;
    if (cargaA) ma <= suma ? ma + mm : ma - mm;
    if (desplazaAQ) {ma, mq} <= {ma[2], ma, mq[3:1]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Runs one multiplication from IDLE and traces the controller until fin.
  task automatic run_mult(input logic [2:0] mr, input logic [2:0] md, output int fin_cyc,
                          output logic [5:0] prod, output logic [5:0] ops,
                          output int nshift, output int busy, output logic [31:0] shmask,
                          output bit bad);
    fin_cyc = -1;
    prod    = 6'h00;
    ops     = 6'h00;
    nshift  = 0;
    busy    = 0;
    shmask  = 32'h0;
    bad     = 1'b0;
    @(negedge clk);
    mcador = mr;
    mcando = md;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (ocupado) busy++;
      if (cargaA && nshift < 3) ops[2*nshift +: 2] = suma ? 2'd1 : 2'd2;
      if (desplazaAQ) begin
        nshift++;
        shmask[c] = 1'b1;
      end
      if (cargaA && desplazaAQ) bad = 1'b1;
      if (c == 1 && !(start && cargaQ && cargaM)) bad = 1'b1;
      if (c != 1 && (start || cargaQ || cargaM)) bad = 1'b1;
      if (fin) begin
        fin_cyc = c;
        prod = {ma, mq[3:1]};
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mult(input string name, input logic [2:0] mr, input logic [2:0] md,
                           input logic [5:0] exp_prod, input logic [5:0] exp_ops,
                           input int exp_fin, input logic [31:0] exp_sh);
    int fc, ns, bz;
    logic [5:0] pr, op;
    logic [31:0] sm;
    bit bad;
    run_mult(mr, md, fc, pr, op, ns, bz, sm, bad);
    checks++;
    if (fc !== exp_fin) begin
      failures++;
      $display("FAIL %s fin_cycle: got %0d expected %0d", name, fc, exp_fin);
    end
    checks++;
    if (pr !== exp_prod) begin
      failures++;
      $display("FAIL %s producto: got %b expected %b", name, pr, exp_prod);
    end
    checks++;
    if (op !== exp_ops) begin
      failures++;
      $display("FAIL %s opera_seq: got %b expected %b", name, op, exp_ops);
    end
    checks++;
    if (sm !== exp_sh) begin
      failures++;
      $display("FAIL %s shift_cycles: got %h expected %h", name, sm, exp_sh);
    end
    checks++;
    if (bz !== exp_fin) begin
      failures++;
      $display("FAIL %s ocupado_cycles: got %0d expected %0d", name, bz, exp_fin);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL %s strobe_rules: got %0d expected 0", name, bad);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL %s idle_after_fin: got %b expected 00000000", name, outs);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset  = 1'b1;
    inicio = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (outs !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs: got %b expected 00000000", outs);
      end
    end
    @(negedge clk);
    reset  = 1'b0;
    inicio = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL reset_release_idle: got %b expected 00000000", outs);
    end
  endtask

  task automatic test_hold_inicio();
    int first_fin = -1;
    int fin_cnt = 0;
    int start_cnt = 0;
    int second_start = -1;
    logic busy_after_fin = 1'b1;
    int fc2 = -1;
    @(negedge clk);
    mcador = 3'b011;
    mcando = 3'b010;
    inicio = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (fin) begin
        fin_cnt++;
        if (first_fin < 0) first_fin = c;
      end
      if (first_fin > 0 && c == first_fin + 1) busy_after_fin = ocupado;
      if (start) begin
        start_cnt++;
        if (c != 1) second_start = c;
      end
    end
    @(negedge clk);
    inicio = 1'b0;
    checks++;
    if (first_fin !== Fin32) begin
      failures++;
      $display("FAIL hold_first_fin: got %0d expected %0d", first_fin, Fin32);
    end
    checks++;
    if (fin_cnt !== 1) begin
      failures++;
      $display("FAIL hold_fin_count: got %0d expected 1", fin_cnt);
    end
    checks++;
    if (start_cnt !== 2) begin
      failures++;
      $display("FAIL hold_start_count: got %0d expected 2", start_cnt);
    end
    checks++;
    if (second_start !== Fin32 + 2) begin
      failures++;
      $display("FAIL hold_restart_cycle: got %0d expected %0d", second_start, Fin32 + 2);
    end
    checks++;
    if (busy_after_fin !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle_after_fin: got %b expected 0", busy_after_fin);
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (fin) begin
        fc2 = c;
        break;
      end
    end
    checks++;
    if (fc2 < 0 || {ma, mq[3:1]} !== 6'b000110) begin
      failures++;
      $display("FAIL hold_second_product: got %b (fin seen %0d) expected 000110",
               {ma, mq[3:1]}, fc2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int shifts = 0;
    bit seen = 1'b0;
    @(negedge clk);
    mcador = 3'b010;
    mcando = 3'b011;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (cargaA) begin
        seen = 1'b1;
        break;
      end
      if (desplazaAQ) shifts++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen || shifts !== 1) begin
      failures++;
      $display("FAIL midrun_second_opera: got seen=%0d shifts=%0d expected seen=1 shifts=1",
               seen, shifts);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL midrun_reset_outputs: got %b expected 00000000", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL midrun_stays_idle: got %b expected 00000000", outs);
    end
    test_mult("after_reset", 3'b011, 3'b010, 6'b000110, 6'b010010, Fin32, Sh32);
  endtask

  initial begin
    reset  = 1'b1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_mult("mul_3x2", 3'b011, 3'b010, 6'b000110, 6'b010010, Fin32, Sh32);
    test_mult("mul_m4x3", 3'b100, 3'b011, 6'b110100, 6'b100000, FinM4, ShM4);
    test_mult("mul_zero", 3'b000, 3'b101, 6'b000000, 6'b000000, Fin0, Sh0);
    test_hold_inicio();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
